// File: rtl/spi_master_mc.sv
// spi_master_mc -- full-duplex SPI master with selectable CPOL/CPHA,
// per-transfer frame length and one-hot active-low chip selects.
//
// Ports
//   clk, rst   system clock, synchronous active-high reset
//   din        tx frame, right-aligned (MSB = din[len-1])
//   len        frame bits; 0 or >MAX_WIDTH selects MAX_WIDTH
//   cs_sel     chip-select index; out-of-range values clock with no CS low
//   vin/ready  request handshake, accepted when vin && ready (IDLE only)
//   dout/vout  rx frame (right-aligned, upper bits zero) and 1-cycle strobe
//   SCK, MOSI, MISO, CS_N   SPI bus
//
// Timing: SETUP holds CS_N low for CS_SETUP cycles. SHIFT is 2*len
// half-periods of HALF cycles, and SCK toggles at the end of each one, so
// SCK sits at CPOL for the first half-period and is back at CPOL when
// HOLD starts. HOLD then keeps CS_N low for exactly CS_HOLD cycles after
// the last edge.
module spi_master_mc #(
    parameter int PRESCALER = 10,
    parameter int MAX_WIDTH = 32,
    parameter int CS_NUM    = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int GAP       = 2,
    localparam int LW = $clog2(MAX_WIDTH + 1),
    localparam int SW = (CS_NUM > 1) ? $clog2(CS_NUM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MAX_WIDTH-1:0] din,
    input  logic [LW-1:0]        len,
    input  logic [SW-1:0]        cs_sel,
    input  logic                 vin,
    output logic                 ready,
    output logic [MAX_WIDTH-1:0] dout,
    output logic                 vout,
    output logic                 SCK,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic [CS_NUM-1:0]    CS_N
);
    localparam int HALF = PRESCALER / 2;
    localparam int M1   = (CS_SETUP > HALF) ? CS_SETUP : HALF;
    localparam int M2   = (CS_HOLD > GAP) ? CS_HOLD : GAP;
    localparam int CMAX = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(HALF - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [LW:0]   H_ONE     = (LW + 1)'(1);
    localparam logic [LW-1:0] MAXW      = LW'(MAX_WIDTH);
    localparam logic          SCK_IDLE  = 1'(CPOL);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP_S} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [LW:0]           half, half_n;      // half-period index within SHIFT
    logic [LW-1:0]         len_r, len_n, len_c;
    logic [MAX_WIDTH-1:0]  tx_sh, tx_n;       // left-aligned, MSB drives MOSI
    logic [MAX_WIDTH-1:0]  rx_sh, rx_n;
    logic [MAX_WIDTH-1:0]  dout_n;
    logic [CS_NUM-1:0]     cs_n_n;
    logic                  sck_n, mosi_n, vout_n;
    logic [LW:0]           last_half;
    logic                  leading;

    assign ready     = (state == IDLE) && !rst;
    assign len_c     = (len == '0 || len > MAXW) ? MAXW : len;
    assign last_half = {len_r, 1'b0} - H_ONE;
    assign leading   = ~half[0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        half_n  = half;
        len_n   = len_r;
        tx_n    = tx_sh;
        rx_n    = rx_sh;
        dout_n  = dout;
        cs_n_n  = CS_N;
        sck_n   = SCK;
        mosi_n  = MOSI;
        vout_n  = 1'b0;
        case (state)
            IDLE: if (vin && ready) begin
                state_n = SETUP;
                cnt_n   = '0;
                half_n  = '0;
                len_n   = len_c;
                tx_n    = din << (MAXW - len_c);
                mosi_n  = tx_n[MAX_WIDTH-1];
                rx_n    = '0;
                for (int i = 0; i < CS_NUM; i++) cs_n_n[i] = (cs_sel != SW'(i));
            end
            SETUP: begin
                if (cnt == SETUP_END) begin
                    state_n = SHIFT;
                    cnt_n   = '0;
                end else cnt_n = cnt + C_ONE;
            end
            SHIFT: begin
                if (cnt == HALF_END) begin
                    cnt_n  = '0;
                    sck_n  = ~SCK;
                    half_n = half + H_ONE;
                    if (leading) begin
                        if (CPHA == 0) rx_n = {rx_sh[MAX_WIDTH-2:0], MISO};
                        // first bit is already on MOSI from SETUP
                        else if (half != '0) begin
                            tx_n   = tx_sh << 1;
                            mosi_n = tx_sh[MAX_WIDTH-2];
                        end
                    end else begin
                        if (CPHA != 0) rx_n = {rx_sh[MAX_WIDTH-2:0], MISO};
                        // no advance after the final bit: MOSI holds through HOLD
                        else if (half != last_half) begin
                            tx_n   = tx_sh << 1;
                            mosi_n = tx_sh[MAX_WIDTH-2];
                        end
                    end
                    if (half == last_half) state_n = HOLD;
                end else cnt_n = cnt + C_ONE;
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    cnt_n   = '0;
                    cs_n_n  = '1;
                    mosi_n  = 1'b0;
                    dout_n  = rx_sh;
                    vout_n  = 1'b1;
                    state_n = (GAP == 0) ? IDLE : GAP_S;
                end else cnt_n = cnt + C_ONE;
            end
            GAP_S: begin
                if (cnt == GAP_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else cnt_n = cnt + C_ONE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            half  <= '0;
            len_r <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
            dout  <= '0;
            vout  <= 1'b0;
            CS_N  <= '1;
            SCK   <= SCK_IDLE;
            MOSI  <= 1'b0;
        end else begin
            cnt   <= cnt_n;
            half  <= half_n;
            len_r <= len_n;
            tx_sh <= tx_n;
            rx_sh <= rx_n;
            dout  <= dout_n;
            vout  <= vout_n;
            CS_N  <= cs_n_n;
            SCK   <= sck_n;
            MOSI  <= mosi_n;
        end
    end
endmodule
